// File: rtl/calendar_date_counter.sv
// Calendar date stage fed by the hour counter's carry/borrow pulses.
// It tracks day, month, two-digit year (2000-2099) and day of week.
// A synchronous load port takes priority over stepping, and every loaded
// field is clamped into range. The counter also reports a century
// carry/borrow when the date wraps past YEAR_MAX or below year 0.
module calendar_date_counter #(
    parameter int YEAR_MAX      = 99,
    parameter int WEEKDAY_RESET = 6
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_load,
    input  logic [4:0] i_load_day,
    input  logic [3:0] i_load_month,
    input  logic [6:0] i_load_year,
    input  logic [2:0] i_load_weekday,
    output logic [4:0] o_day,
    output logic [3:0] o_month,
    output logic [6:0] o_year,
    output logic [2:0] o_weekday,
    output logic       o_carryup,
    output logic       o_borrowdown
);

    localparam logic [6:0] YEAR_MAX_C   = 7'(YEAR_MAX);
    localparam logic [2:0] WD_RESET_C   = 3'(WEEKDAY_RESET);

    // Days in a month. A year is a leap year when its two low bits are zero,
    // which holds for every year from 2000 to 2099.
    function automatic logic [4:0] month_max(input logic [3:0] month, input logic [6:0] year);
        logic [4:0] m;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: m = 5'd30;
            4'd2: begin
                if (year[1:0] == 2'b00) m = 5'd29;
                else                    m = 5'd28;
            end
            default: m = 5'd31;
        endcase
        return m;
    endfunction

    logic [4:0] day_q,     day_d;
    logic [3:0] month_q,   month_d;
    logic [6:0] year_q,    year_d;
    logic [2:0] weekday_q, weekday_d;

    logic [4:0] cur_max_s;
    logic [3:0] prev_month_s;
    logic [4:0] prev_max_s;
    logic [3:0] ld_month_s;
    logic [6:0] ld_year_s;
    logic [4:0] ld_max_s;
    logic       step_up_s;
    logic       step_down_s;

    assign step_up_s    = i_up & ~i_down & ~i_load;
    assign step_down_s  = i_down & ~i_up & ~i_load;
    assign cur_max_s    = month_max(month_q, year_q);
    assign prev_month_s = month_q - 4'd1;
    assign prev_max_s   = month_max(prev_month_s, year_q);

    // Clamp the load month and year into range. The day is clamped
    // against the length of this clamped month.
    always_comb begin
        ld_month_s = i_load_month;
        if (i_load_month == 4'd0) begin
            ld_month_s = 4'd1;
        end else if (i_load_month > 4'd12) begin
            ld_month_s = 4'd12;
        end else begin
            ld_month_s = i_load_month;
        end
        if (i_load_year > YEAR_MAX_C) begin
            ld_year_s = YEAR_MAX_C;
        end else begin
            ld_year_s = i_load_year;
        end
        ld_max_s = month_max(ld_month_s, ld_year_s);
    end

    // Next-state selection: load wins; a single up or down steps; anything else holds.
    always_comb begin
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        weekday_d = weekday_q;
        if (i_load) begin
            month_d = ld_month_s;
            year_d  = ld_year_s;
            if (i_load_day == 5'd0) begin
                day_d = 5'd1;
            end else if (i_load_day > ld_max_s) begin
                day_d = ld_max_s;
            end else begin
                day_d = i_load_day;
            end
            if (i_load_weekday == 3'd7) begin
                weekday_d = 3'd0;
            end else begin
                weekday_d = i_load_weekday;
            end
        end else if (step_up_s) begin
            if (day_q < cur_max_s) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d = 5'd1;
                if (month_q < 4'd12) begin
                    month_d = month_q + 4'd1;
                end else begin
                    month_d = 4'd1;
                    if (year_q >= YEAR_MAX_C) year_d = 7'd0;
                    else                      year_d = year_q + 7'd1;
                end
            end
            if (weekday_q >= 3'd6) weekday_d = 3'd0;
            else                   weekday_d = weekday_q + 3'd1;
        end else if (step_down_s) begin
            if (day_q > 5'd1) begin
                day_d = day_q - 5'd1;
            end else if (month_q > 4'd1) begin
                month_d = prev_month_s;
                day_d   = prev_max_s;
            end else begin
                month_d = 4'd12;
                day_d   = 5'd31;
                if (year_q == 7'd0) year_d = YEAR_MAX_C;
                else                year_d = year_q - 7'd1;
            end
            if (weekday_q == 3'd0) weekday_d = 3'd6;
            else                   weekday_d = weekday_q - 3'd1;
        end else begin
            day_d     = day_q;
            month_d   = month_q;
            year_d    = year_q;
            weekday_d = weekday_q;
        end
    end

    // Date registers; asynchronous reset to 2000-01-01.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            day_q     <= 5'd1;
            month_q   <= 4'd1;
            year_q    <= 7'd0;
            weekday_q <= WD_RESET_C;
        end else begin
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            weekday_q <= weekday_d;
        end
    end

    assign o_day     = day_q;
    assign o_month   = month_q;
    assign o_year    = year_q;
    assign o_weekday = weekday_q;

    // The century flags are valid in the same cycle as the step that wraps.
    assign o_carryup    = step_up_s & (day_q == 5'd31) & (month_q == 4'd12) & (year_q == YEAR_MAX_C);
    assign o_borrowdown = step_down_s & (day_q == 5'd1) & (month_q == 4'd1) & (year_q == 7'd0);

endmodule

// File: tb/tb_calendar_date_counter.sv
// Self-checking bench for calendar_date_counter using an expected-value queue.
module tb_calendar_date_counter;

    typedef struct packed {
        logic [4:0] d;
        logic [3:0] m;
        logic [6:0] y;
        logic [2:0] w;
    } date_t;

    logic       i_clk;
    logic       i_rstn;
    logic       i_up;
    logic       i_down;
    logic       i_load;
    logic [4:0] i_load_day;
    logic [3:0] i_load_month;
    logic [6:0] i_load_year;
    logic [2:0] i_load_weekday;
    logic [4:0] o_day;
    logic [3:0] o_month;
    logic [6:0] o_year;
    logic [2:0] o_weekday;
    logic       o_carryup;
    logic       o_borrowdown;

    int    total;
    int    bad;
    date_t exp_q[$];
    date_t cur;
    date_t got;
    date_t want;

    calendar_date_counter #(.YEAR_MAX(99), .WEEKDAY_RESET(6)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_up           (i_up),
        .i_down         (i_down),
        .i_load         (i_load),
        .i_load_day     (i_load_day),
        .i_load_month   (i_load_month),
        .i_load_year    (i_load_year),
        .i_load_weekday (i_load_weekday),
        .o_day          (o_day),
        .o_month        (o_month),
        .o_year         (o_year),
        .o_weekday      (o_weekday),
        .o_carryup      (o_carryup),
        .o_borrowdown   (o_borrowdown)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    assign got = '{d: o_day, m: o_month, y: o_year, w: o_weekday};

    function automatic date_t mk(input int d, input int m, input int y, input int w);
        date_t r;
        r.d = 5'(d); r.m = 4'(m); r.y = 7'(y); r.w = 3'(w);
        return r;
    endfunction

    function automatic int dim(input int m, input int y);
        int t[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && (y % 4) == 0) return 29;
        return t[m];
    endfunction

    // Reference calendar: one day forward (up=1) or backward (up=0).
    function automatic date_t model_step(input date_t c, input bit up);
        int d = int'(c.d), m = int'(c.m), y = int'(c.y), w = int'(c.w);
        if (up) begin
            d = d + 1;
            if (d > dim(m, y)) begin
                d = 1; m = m + 1;
                if (m > 12) begin m = 1; y = (y + 1) % 100; end
            end
            w = (w + 1) % 7;
        end else begin
            d = d - 1;
            if (d < 1) begin
                m = m - 1;
                if (m < 1) begin m = 12; y = (y + 99) % 100; end
                d = dim(m, y);
            end
            w = (w + 6) % 7;
        end
        return mk(d, m, y, w);
    endfunction

    // Drive one cycle's inputs at the falling edge.
    task automatic apply(input logic up, input logic down, input logic load, input date_t ld);
        @(negedge i_clk);
        i_up = up; i_down = down; i_load = load;
        i_load_day = ld.d; i_load_month = ld.m; i_load_year = ld.y; i_load_weekday = ld.w;
    endtask

    task automatic wait_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rstn = 1'b1;
        apply(1'b0, 1'b0, 1'b0, '0);
        #2 i_rstn = 1'b0;
        #1;
        want = mk(1, 1, 0, 6);
        total++;
        if (got !== want) begin bad++; $display("FAIL reset_value got=%h exp=%h", got, want); end
        total++;
        if ({o_carryup, o_borrowdown} !== 2'b00) begin
            bad++; $display("FAIL reset_flags got=%b exp=00", {o_carryup, o_borrowdown});
        end
        wait_edge();
        #2 i_rstn = 1'b1;
        cur = want;
    endtask

    task automatic test_increment();
        for (int i = 0; i < 31; i++) begin
            apply(1'b1, 1'b0, 1'b0, '0);
            cur = model_step(cur, 1'b1);
            exp_q.push_back(cur);
            wait_edge();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL inc_step%0d got=%h exp=%h", i, got, want); end
        end
        want = mk(1, 2, 0, 2);
        total++;
        if (got !== want) begin bad++; $display("FAIL inc_feb1 got=%h exp=%h", got, want); end
        for (int i = 0; i < 28; i++) begin
            apply(1'b1, 1'b0, 1'b0, '0);
            cur = model_step(cur, 1'b1);
            exp_q.push_back(cur);
            wait_edge();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL inc_feb_step%0d got=%h exp=%h", i, got, want); end
        end
        want = mk(29, 2, 0, 2);
        total++;
        if (got !== want) begin bad++; $display("FAIL inc_leap29 got=%h exp=%h", got, want); end
        apply(1'b1, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1, 3, 0, 3));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL inc_leap_mar1 got=%h exp=%h", got, want); end
        apply(1'b0, 1'b0, 1'b1, mk(28, 2, 1, 2));
        exp_q.push_back(mk(28, 2, 1, 2));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL load_feb28 got=%h exp=%h", got, want); end
        apply(1'b1, 1'b0, 1'b0, '0);
        exp_q.push_back(mk(1, 3, 1, 3));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL inc_nonleap_mar1 got=%h exp=%h", got, want); end
    endtask

    task automatic test_decrement();
        date_t ld[2]   = '{mk(1, 3, 1, 4), mk(1, 3, 4, 1)};
        date_t res[2]  = '{mk(28, 2, 1, 3), mk(29, 2, 4, 0)};
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b1, ld[i]);
            exp_q.push_back(ld[i]);
            wait_edge();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL dec_load%0d got=%h exp=%h", i, got, want); end
            apply(1'b0, 1'b1, 1'b0, '0);
            exp_q.push_back(res[i]);
            wait_edge();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL dec_result%0d got=%h exp=%h", i, got, want); end
        end
    endtask

    task automatic test_century();
        apply(1'b0, 1'b0, 1'b1, mk(31, 12, 99, 0));
        wait_edge();
        apply(1'b1, 1'b0, 1'b0, '0);
        #1;
        total++;
        if (o_carryup !== 1'b1) begin bad++; $display("FAIL carry_high got=%b exp=1", o_carryup); end
        exp_q.push_back(mk(1, 1, 0, 1));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL century_up got=%h exp=%h", got, want); end
        total++;
        if (o_carryup !== 1'b0) begin bad++; $display("FAIL carry_low got=%b exp=0", o_carryup); end
        apply(1'b0, 1'b1, 1'b0, '0);
        #1;
        total++;
        if (o_borrowdown !== 1'b1) begin bad++; $display("FAIL borrow_high got=%b exp=1", o_borrowdown); end
        exp_q.push_back(mk(31, 12, 99, 0));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL century_down got=%h exp=%h", got, want); end
        total++;
        if (o_borrowdown !== 1'b0) begin bad++; $display("FAIL borrow_low got=%b exp=0", o_borrowdown); end
    endtask

    task automatic test_load_sanitise();
        date_t ld[4]  = '{mk(31, 4, 5, 3), mk(0, 15, 120, 7), mk(30, 2, 3, 5), mk(17, 0, 50, 6)};
        date_t res[4] = '{mk(30, 4, 5, 3), mk(1, 12, 99, 0), mk(28, 2, 3, 5), mk(17, 1, 50, 6)};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b1, ld[i]);
            exp_q.push_back(res[i]);
            wait_edge();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL sanitise%0d got=%h exp=%h", i, got, want); end
        end
    endtask

    task automatic test_priority();
        apply(1'b0, 1'b0, 1'b1, mk(31, 12, 99, 0));
        wait_edge();
        apply(1'b1, 1'b0, 1'b1, mk(10, 6, 20, 2));
        #1;
        total++;
        if (o_carryup !== 1'b0) begin bad++; $display("FAIL load_up_carry got=%b exp=0", o_carryup); end
        exp_q.push_back(mk(10, 6, 20, 2));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL load_over_up got=%h exp=%h", got, want); end
        apply(1'b0, 1'b1, 1'b1, mk(1, 1, 0, 4));
        #1;
        total++;
        if (o_borrowdown !== 1'b0) begin bad++; $display("FAIL load_down_borrow got=%b exp=0", o_borrowdown); end
        exp_q.push_back(mk(1, 1, 0, 4));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL load_over_down got=%h exp=%h", got, want); end
        apply(1'b1, 1'b1, 1'b0, '0);
        #1;
        total++;
        if ({o_carryup, o_borrowdown} !== 2'b00) begin
            bad++; $display("FAIL both_flags got=%b exp=00", {o_carryup, o_borrowdown});
        end
        exp_q.push_back(mk(1, 1, 0, 4));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL both_hold got=%h exp=%h", got, want); end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 1'b0, 1'b1, mk(15, 7, 0, 6));
        wait_edge();
        apply(1'b1, 1'b0, 1'b0, '0);
        #1 i_rstn = 1'b0;
        #1;
        want = mk(1, 1, 0, 6);
        total++;
        if (got !== want) begin bad++; $display("FAIL mid_reset got=%h exp=%h", got, want); end
        #1 i_rstn = 1'b1;
        exp_q.push_back(mk(2, 1, 0, 0));
        wait_edge();
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin bad++; $display("FAIL after_release got=%h exp=%h", got, want); end
    endtask

    task automatic test_back_to_back();
        for (int blk = 0; blk < 6; blk++) begin
            int y = int'($urandom_range(99, 0));
            int m = int'($urandom_range(12, 1));
            int d = int'($urandom_range(dim(m, y), 1));
            cur = mk(d, m, y, int'($urandom_range(6, 0)));
            apply(1'b0, 1'b0, 1'b1, cur);
            exp_q.push_back(cur);
            wait_edge();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL b2b_load%0d got=%h exp=%h", blk, got, want); end
            for (int i = 0; i < 60; i++) begin
                int r = int'($urandom_range(3, 0));
                bit up = (r < 2) ? ((blk % 2) == 0) : ((blk % 2) != 0);
                if (r == 3) begin
                    apply(1'b0, 1'b0, 1'b0, '0);
                end else begin
                    apply(up, !up, 1'b0, '0);
                    cur = model_step(cur, up);
                end
                exp_q.push_back(cur);
                wait_edge();
                want = exp_q.pop_front();
                total++;
                if (got !== want) begin bad++; $display("FAIL b2b_%0d_%0d got=%h exp=%h", blk, i, got, want); end
            end
        end
        apply(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rstn = 1'b1;
        i_up = 1'b0; i_down = 1'b0; i_load = 1'b0;
        i_load_day = 5'd0; i_load_month = 4'd0; i_load_year = 7'd0; i_load_weekday = 3'd0;
        test_reset();
        test_increment();
        test_decrement();
        test_century();
        test_load_sanitise();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
